writeback_buffer: RTL and testbench

Two-entry write-back buffer between the L1 data cache and physical memory. When the cache evicts a dirty 128-bit line (the merged line produced by the cache's store-merge path), it pushes the line here and continues without waiting. The buffer drains entries to pmem in FIFO order whenever the cache is not using pmem. It coalesces repeated evictions of the same line, and forwards buffered data to cache refills so no stale line is ever read back.

---
 rtl/writeback_buffer_if.sv | 36 +++
 rtl/writeback_buffer.sv | 133 +++++++++++++
 tb/tb_writeback_buffer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_buffer_if.sv
// writeback_buffer_if
// Bundles the cache-side and pmem-side signals of the write-back buffer.
//   wb_write/wb_addr/wb_wdata    : dirty-line push from the cache
//   wb_full/wb_empty             : occupancy status back to the cache
//   lookup_addr/hit/data         : refill forwarding lookup
//   drain_inhibit                : cache owns pmem this cycle
//   pmem_write/address/wdata     : drain request to physical memory
//   pmem_resp                    : drain write completed
// master = cache/memory environment, slave = the buffer itself.
interface writeback_buffer_if;
  logic         wb_write;
  logic [15:0]  wb_addr;
  logic [127:0] wb_wdata;
  logic         wb_full;
  logic         wb_empty;
  logic [15:0]  lookup_addr;
  logic         lookup_hit;
  logic [127:0] lookup_data;
  logic         drain_inhibit;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;

  modport master (
    output wb_write, wb_addr, wb_wdata, lookup_addr, drain_inhibit, pmem_resp,
    input  wb_full, wb_empty, lookup_hit, lookup_data,
           pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  wb_write, wb_addr, wb_wdata, lookup_addr, drain_inhibit, pmem_resp,
    output wb_full, wb_empty, lookup_hit, lookup_data,
           pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/writeback_buffer.sv
// writeback_buffer
// Two-entry FIFO of evicted dirty 128-bit lines sitting between the L1
// data cache and physical memory. Repeated evictions of a buffered line are
// coalesced, refills are served from the youngest buffered copy, and the
// head entry is written to pmem whenever the cache is not using pmem.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; discards all buffered lines
//   bus   : writeback_buffer_if.slave (push, status, lookup, pmem drain)
module writeback_buffer (
  input  logic                clk,
  input  logic                reset,
  writeback_buffer_if.slave   bus
);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e       state_q, state_d;
  logic [1:0]   valid_q, valid_d;
  logic [11:0]  addr_q [2];
  logic [11:0]  addr_d [2];
  logic [127:0] data_q [2];
  logic [127:0] data_d [2];
  logic         head_q, head_d;
  logic [1:0]   count_q, count_d;

  logic        draining;
  logic        pop;
  logic [11:0] push_tag;
  logic        tail;
  logic        older_match;
  logic        younger_match;
  logic        coal_idx;
  logic        coalesce;
  logic        alloc;

  // Line-offset bits carry no meaning for either the push or the lookup.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{bus.wb_addr[3:0], bus.lookup_addr[3:0]};

  assign draining = (state_q == DRAIN);
  assign pop      = draining && bus.pmem_resp;
  assign push_tag = bus.wb_addr[15:4];
  assign tail     = head_q ^ count_q[0];

  // The head entry is frozen while it is being written to pmem, so it is
  // not a coalesce candidate in DRAIN; the slot after it always is.
  assign older_match   = valid_q[head_q] && (addr_q[head_q] == push_tag) && !draining;
  assign younger_match = valid_q[~head_q] && (addr_q[~head_q] == push_tag);
  assign coal_idx      = younger_match ? ~head_q : head_q;
  assign coalesce      = bus.wb_write && (older_match || younger_match);
  // A full buffer can still take a line when the head pops on this edge;
  // the tail slot is then the slot being vacated.
  assign alloc         = bus.wb_write && !(older_match || younger_match) &&
                         ((count_q != 2'd2) || pop);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    count_d = count_q + {1'b0, alloc} - {1'b0, pop};

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = ~head_q;
    end
    if (coalesce) begin
      data_d[coal_idx] = bus.wb_wdata;
    end
    // Ordered after the pop so a same-edge allocate into the vacated slot
    // leaves it valid.
    if (alloc) begin
      valid_d[tail] = 1'b1;
      addr_d[tail]  = push_tag;
      data_d[tail]  = bus.wb_wdata;
    end

    case (state_q)
      IDLE:    if ((count_q != 2'd0) && !bus.drain_inhibit) state_d = DRAIN;
      DRAIN:   if (bus.pmem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      head_q  <= 1'b0;
      count_q <= '0;
      // NOTE: the entry storage is reset too, because pmem_address and
      // pmem_wdata expose the head slot directly and must read 0 after reset.
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  // Youngest match wins: the slot after the head is the newer one.
  always_comb begin
    bus.lookup_hit  = 1'b0;
    bus.lookup_data = '0;
    if (valid_q[head_q] && (addr_q[head_q] == bus.lookup_addr[15:4])) begin
      bus.lookup_hit  = 1'b1;
      bus.lookup_data = data_q[head_q];
    end
    if (valid_q[~head_q] && (addr_q[~head_q] == bus.lookup_addr[15:4])) begin
      bus.lookup_hit  = 1'b1;
      bus.lookup_data = data_q[~head_q];
    end
  end

  assign bus.wb_full      = (count_q == 2'd2);
  assign bus.wb_empty     = (count_q == 2'd0);
  assign bus.pmem_write   = draining;
  assign bus.pmem_address = {addr_q[head_q], 4'h0};
  assign bus.pmem_wdata   = data_q[head_q];

endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer
// Directed scenarios plus randomized traffic against a queue-based model of
// the buffer. Drain writes expected by the model go into a scoreboard queue;
// a monitor process compares them whenever the buffer starts a pmem write.
module tb_writeback_buffer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  writeback_buffer_if bus ();

  writeback_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [11:0]  tag;
    logic [127:0] data;
  } line_t;

  typedef struct {
    logic [15:0]  addr;
    logic [127:0] data;
  } wr_t;

  line_t mq[$];      // buffered lines, oldest first
  wr_t   exp_q[$];   // drain writes the model expects, in order
  bit    m_drain;    // model: head is currently being written
  logic [15:0] cur_la;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [127:0] D0 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
  localparam logic [127:0] DA = 128'haaaa_0000_aaaa_1111_aaaa_2222_aaaa_3333;
  localparam logic [127:0] DB = 128'hbbbb_0000_bbbb_1111_bbbb_2222_bbbb_3333;
  localparam logic [127:0] DC = 128'hcccc_0000_cccc_1111_cccc_2222_cccc_3333;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference behaviour of one clock edge, from the buffer's rules.
  task automatic model_edge(input bit w, input logic [15:0] a, input logic [127:0] d,
                            input bit inh, input bit rsp);
    int j   = -1;
    int pre = mq.size();
    bit pop = m_drain && rsp;
    if (w) begin
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].tag == a[15:4] && !(m_drain && i == 0)) j = i;
    end
    if (w && j >= 0) mq[j].data = d;
    if (pop) void'(mq.pop_front());
    if (w && j < 0 && (pre < 2 || pop)) mq.push_back('{a[15:4], d});
    if (m_drain) begin
      if (rsp) m_drain = 1'b0;
    end else if (pre != 0 && !inh) begin
      m_drain = 1'b1;
      exp_q.push_back('{{mq[0].tag, 4'h0}, mq[0].data});
    end
  endtask

  task automatic check_outputs();
    logic         hit = 1'b0;
    logic [127:0] ld  = '0;
    foreach (mq[i]) begin
      if (mq[i].tag == cur_la[15:4]) begin
        hit = 1'b1;
        ld  = mq[i].data;
      end
    end
    check("wb_empty", bus.wb_empty, mq.size() == 0);
    check("wb_full", bus.wb_full, mq.size() == 2);
    check("pmem_write", bus.pmem_write, m_drain);
    check("lookup_hit", bus.lookup_hit, hit);
    check("lookup_data", bus.lookup_data, ld);
    if (m_drain && mq.size() != 0) begin
      check("pmem_address", bus.pmem_address, {mq[0].tag, 4'h0});
      check("pmem_wdata", bus.pmem_wdata, mq[0].data);
    end
  endtask

  // Drive one cycle of inputs, check outputs, then advance past the edge.
  task automatic step(input bit w, input logic [15:0] a, input logic [127:0] d,
                      input bit inh, input bit rsp, input logic [15:0] la);
    bus.wb_write      = w;
    bus.wb_addr       = a;
    bus.wb_wdata      = d;
    bus.drain_inhibit = inh;
    bus.pmem_resp     = rsp;
    bus.lookup_addr   = la;
    cur_la            = la;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge(w, a, d, inh, rsp);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.wb_write  = 1'b0;
    bus.pmem_resp = 1'b0;
    @(posedge clk);
    mq.delete();
    exp_q.delete();
    m_drain = 1'b0;
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard monitor: each new pmem write must match the next expected
  // drain and stay stable until it completes.
  wr_t cur_wr;
  bit  prev_pw = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_pw = 1'b0;
    end else begin
      if (bus.pmem_write) begin
        if (!prev_pw) begin
          check("drain_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            cur_wr = exp_q.pop_front();
            check("drain_addr", bus.pmem_address, cur_wr.addr);
            check("drain_data", bus.pmem_wdata, cur_wr.data);
          end
        end else begin
          check("drain_addr_stable", bus.pmem_address, cur_wr.addr);
          check("drain_data_stable", bus.pmem_wdata, cur_wr.data);
        end
      end
      prev_pw = bus.pmem_write;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bases [3];
    bases = '{16'h1000, 16'h2000, 16'h3000};
    m_drain = 1'b0;
    cur_la  = 16'h0000;
    reset   = 1'b1;
    bus.wb_write = 1'b0; bus.wb_addr = '0; bus.wb_wdata = '0;
    bus.drain_inhibit = 1'b0; bus.pmem_resp = 1'b0; bus.lookup_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values
    check("rst_pmem_write", bus.pmem_write, 1'b0);
    check("rst_pmem_address", bus.pmem_address, 16'h0);
    check("rst_pmem_wdata", bus.pmem_wdata, 128'h0);
    check("rst_empty", bus.wb_empty, 1'b1);
    check("rst_full", bus.wb_full, 1'b0);
    check("rst_lookup_hit", bus.lookup_hit, 1'b0);
    check("rst_lookup_data", bus.lookup_data, 128'h0);

    // Single push drains two cycles later; one-cycle IDLE after resp
    step(1, 16'h1230, D0, 0, 0, 16'h0);
    check("t1_empty_e1", bus.wb_empty, 1'b0);
    check("t1_pw_e1", bus.pmem_write, 1'b0);
    step(0, 16'h0, '0, 0, 0, 16'h1230);
    check("t1_pw_e2", bus.pmem_write, 1'b1);
    check("t1_addr", bus.pmem_address, 16'h1230);
    check("t1_data", bus.pmem_wdata, D0);
    step(0, 16'h0, '0, 0, 1, 16'h0);
    check("t1_pw_after_resp", bus.pmem_write, 1'b0);
    check("t1_empty_after_resp", bus.wb_empty, 1'b1);
    do_reset();

    // Fill while inhibited, drop a third push, then drain in order
    step(1, 16'h1000, DA, 1, 0, 16'h0);
    step(1, 16'h2000, DB, 1, 0, 16'h0);
    check("t2_full", bus.wb_full, 1'b1);
    step(1, 16'h3000, DC, 1, 0, 16'h3000);
    check("t2_drop_nohit", bus.lookup_hit, 1'b0);
    check("t2_still_full", bus.wb_full, 1'b1);
    step(0, 16'h0, '0, 0, 0, 16'h0);
    check("t2_first_addr", bus.pmem_address, 16'h1000);
    step(0, 16'h0, '0, 0, 1, 16'h0);
    check("t2_idle_gap", bus.pmem_write, 1'b0);
    step(0, 16'h0, '0, 0, 0, 16'h0);
    check("t2_second_pw", bus.pmem_write, 1'b1);
    check("t2_second_addr", bus.pmem_address, 16'h2000);
    step(0, 16'h0, '0, 0, 1, 16'h0);
    check("t2_final_empty", bus.wb_empty, 1'b1);
    do_reset();

    // Coalesce into the same line while inhibited
    step(1, 16'h4000, DA, 1, 0, 16'h0);
    step(1, 16'h4008, DB, 1, 0, 16'h0);
    check("t3_not_full", bus.wb_full, 1'b0);
    check("t3_not_empty", bus.wb_empty, 1'b0);
    step(0, 16'h0, '0, 0, 0, 16'h0);
    check("t3_addr", bus.pmem_address, 16'h4000);
    check("t3_data", bus.pmem_wdata, DB);
    step(0, 16'h0, '0, 0, 1, 16'h0);
    do_reset();

    // Push to the draining line allocates a second entry
    step(1, 16'h5000, DA, 0, 0, 16'h0);
    step(0, 16'h0, '0, 0, 0, 16'h0);
    check("t4_pw", bus.pmem_write, 1'b1);
    step(1, 16'h5000, DB, 0, 0, 16'h0);
    check("t4_head_stable", bus.pmem_wdata, DA);
    check("t4_full", bus.wb_full, 1'b1);
    step(0, 16'h0, '0, 0, 1, 16'h0);
    check("t4_idle", bus.pmem_write, 1'b0);
    step(0, 16'h0, '0, 0, 0, 16'h0);
    check("t4_second_addr", bus.pmem_address, 16'h5000);
    check("t4_second_data", bus.pmem_wdata, DB);
    step(0, 16'h0, '0, 0, 1, 16'h0);
    do_reset();

    // Lookup forwarding, including the head during its drain
    step(1, 16'h6000, DA, 1, 0, 16'h0);
    step(1, 16'h7000, DB, 1, 0, 16'h0);
    step(0, 16'h0, '0, 1, 0, 16'h600C);
    check("t5_hit", bus.lookup_hit, 1'b1);
    check("t5_data", bus.lookup_data, DA);
    step(0, 16'h0, '0, 1, 0, 16'h8000);
    check("t5_miss", bus.lookup_hit, 1'b0);
    check("t5_miss_data", bus.lookup_data, 128'h0);
    step(0, 16'h0, '0, 0, 0, 16'h6000);
    check("t5_drain_hit", bus.lookup_hit, 1'b1);
    check("t5_drain_data", bus.lookup_data, DA);
    step(0, 16'h0, '0, 1, 1, 16'h6000);
    check("t5_popped_miss", bus.lookup_hit, 1'b0);
    do_reset();

    // Reset in the middle of a drain with two entries
    step(1, 16'h1000, DA, 1, 0, 16'h0);
    step(1, 16'h2000, DB, 1, 0, 16'h0);
    step(0, 16'h0, '0, 0, 0, 16'h1000);
    check("t6_pw", bus.pmem_write, 1'b1);
    check("t6_full", bus.wb_full, 1'b1);
    do_reset();
    check("t6_pw_after_reset", bus.pmem_write, 1'b0);
    check("t6_empty_after_reset", bus.wb_empty, 1'b1);
    check("t6_hit_after_reset", bus.lookup_hit, 1'b0);
    check("t6_addr_after_reset", bus.pmem_address, 16'h0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      bit           w;
      logic [15:0]  a;
      logic [127:0] d;
      bit           inh;
      bit           rsp;
      logic [15:0]  la;
      w   = ($urandom % 3) == 0;
      a   = bases[$urandom % 3] | 16'($urandom % 16);
      d   = {$urandom, $urandom, $urandom, $urandom};
      inh = ($urandom % 4) == 0;
      rsp = m_drain ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
      la  = ($urandom % 4 != 0) ? (bases[$urandom % 3] | 16'($urandom % 16))
                                : 16'($urandom);
      step(w, a, d, inh, rsp, la);
    end

    // Drain whatever is left, bounded
    for (int c = 0; c < 40; c++) begin
      if (mq.size() == 0 && !m_drain) break;
      step(0, 16'h0, '0, 0, m_drain, 16'h0);
    end
    step(0, 16'h0, '0, 0, 0, 16'h0);
    check("end_empty", bus.wb_empty, 1'b1);
    check("end_pw", bus.pmem_write, 1'b0);
    check("end_no_missing_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
